id_ex_skid_seg: RTL and testbench

Parametrised pipeline segment register with a valid/ready handshake and a built-in 2-entry skid buffer. It is the successor to the fixed-field ID/EX latch. Every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates it with a packed control+data bus. Back-pressure comes from `out_ready` rather than a global stall, and `in_ready` is driven purely from a flop, so stall timing does not chain across stages. A saturating stall-cycle counter gives per-stage performance visibility.

---
 rtl/id_ex_skid_seg.sv | 169 ++++++++++++++++
 tb/tb_id_ex_skid_seg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_seg.sv
// -----------------------------------------------------------------------------
// id_ex_skid_seg
//
// Generic pipeline segment register with a valid/ready handshake and a
// two-entry skid buffer. It sits on every inter-stage boundary (IF/ID, ID/EX,
// EX/MEM, MEM/WB) and carries a packed control+data payload.
//
// Back-pressure arrives through out_ready. in_ready is the inverse of the skid
// valid flop, so there is no combinational path from out_ready to in_ready and
// stall timing does not ripple across stages. A saturating counter records how
// many cycles the stage held valid data that downstream refused.
//
// Parameters
//   DATA_W    : payload width
//   RESET_VAL : payload loaded into both data registers on reset and on flush
//   CNT_W     : stall-cycle counter width
//
// Ports
//   Clk           in  : rising-edge clock
//   Rst           in  : asynchronous active-high reset
//   flush         in  : synchronous kill of all held entries
//   in_valid      in  : upstream payload valid
//   in_ready      out : stage can accept (registered, = ~skid_v)
//   in_data       in  : upstream payload
//   out_valid     out : downstream payload valid (= main_v)
//   out_ready     in  : downstream accepts
//   out_data      out : payload held in the main register
//   stall_cnt     out : saturating count of out_valid & ~out_ready cycles
//   stall_cnt_clr in  : synchronous clear of stall_cnt (wins over increment)
// -----------------------------------------------------------------------------
module id_ex_skid_seg #(
    parameter int unsigned              DATA_W    = 32,
    parameter logic [DATA_W-1:0]        RESET_VAL = '0,
    parameter int unsigned              CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    // State bits are literally {main_v, skid_v}; 2'b01 can never be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_nxt;

    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic [DATA_W-1:0] main_d_nxt;
    logic [DATA_W-1:0] skid_d_nxt;

    logic              main_v;
    logic              skid_v;
    logic              accept;
    logic              fire;
    logic              stall;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // ---- output decode from the state flops --------------------------------
    always_comb begin
        main_v    = state_q[1];
        skid_v    = state_q[0];
        out_valid = main_v;
        out_data  = main_d;
        in_ready  = ~skid_v;
    end

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;
    assign stall  = out_valid & ~out_ready;

    // ---- next-state and data steering --------------------------------------
    always_comb begin
        state_nxt  = state_q;
        main_d_nxt = main_d;
        skid_d_nxt = skid_d;

        if (flush) begin
            // Flush beats any accept/fire in the same cycle.
            state_nxt  = EMPTY;
            main_d_nxt = RESET_VAL;
            skid_d_nxt = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d_nxt = in_data;
                        state_nxt  = BUSY;
                    end
                end
                BUSY: begin
                    if (accept && fire) begin
                        main_d_nxt = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new payload in skid.
                        skid_d_nxt = in_data;
                        state_nxt  = FULL;
                    end else if (fire) begin
                        state_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a fire can happen.
                    if (fire) begin
                        main_d_nxt = skid_d;
                        state_nxt  = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ---- state register ----------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---- payload registers -------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_d <= RESET_VAL;
            skid_d <= RESET_VAL;
        end else begin
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

    // ---- stall counter (independent of flush) ------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_skid_seg.sv
module tb_id_ex_skid_seg;

    localparam int unsigned      DATA_W = 32;
    localparam int unsigned      CNT_W  = 4;
    localparam logic [31:0]      RVAL   = 32'hDEAD_BEEF;
    localparam int unsigned      CMAX   = 15;

    logic              Clk;
    logic              Rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_cnt_clr;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    id_ex_skid_seg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RVAL),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .stall_cnt     (stall_cnt),
        .stall_cnt_clr (stall_cnt_clr)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    // Reference: a FIFO of at most two payloads, the last departed payload
    // (what the output shows when empty) and a saturating stall counter.
    logic [31:0] mq[$];
    logic [31:0] m_last;
    int unsigned m_cnt;

    task automatic model_reset();
        mq.delete();
        m_last = RVAL;
        m_cnt  = 0;
    endtask

    always @(posedge Clk) begin
        if (Rst) begin
            model_reset();
        end else begin
            bit stl, acc, fr;
            stl = (mq.size() > 0) && !out_ready;
            acc = in_valid && (mq.size() < 2);
            fr  = (mq.size() > 0) && out_ready;
            if (stall_cnt_clr) m_cnt = 0;
            else if (stl && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (flush) begin
                mq.delete();
                m_last = RVAL;
            end else begin
                if (fr) m_last = mq.pop_front();
                if (acc) mq.push_back(in_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference, on the falling edge.
    always @(negedge Clk) begin
        if (chk_en && !Rst) begin
            logic [31:0] exp_d;
            exp_d = (mq.size() > 0) ? mq[0] : m_last;
            chk("m_out_valid", out_valid, (mq.size() > 0));
            chk("m_in_ready",  in_ready,  (mq.size() < 2));
            chk("m_skid_v",    dut.skid_v, (mq.size() == 2));
            chk("m_in_ready_eq_not_skid", in_ready, !dut.skid_v);
            chk("m_out_data",  out_data,  exp_d);
            chk("m_stall_cnt", stall_cnt, m_cnt);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Rst = 1; flush = 0; in_valid = 0; in_data = '0;
        out_ready = 0; stall_cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #2;
        Rst = 0;
        chk_en = 1;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_data",  out_data,  RVAL);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Streaming 1..100 with out_ready held high
        out_ready = 1;
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1;
            in_data  = i;
            step();
            chk("stream_data",  out_data,  i);
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 0;
        step();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_stall_cnt",   stall_cnt, 0);

        // Skid: A in main, B into skid, C refused, release after 3 stalls
        in_valid = 1; in_data = 32'hA; out_ready = 1; stall_cnt_clr = 1;
        step();
        stall_cnt_clr = 0;
        chk("skid_a_main", out_data, 32'hA);
        out_ready = 0; in_data = 32'hB;
        step();
        chk("skid_b_in_ready", in_ready, 0);
        chk("skid_hold_a1",    out_data, 32'hA);
        in_data = 32'hC;
        step();
        chk("skid_hold_a2",    out_data, 32'hA);
        chk("skid_c_refused",  in_ready, 0);
        step();
        chk("skid_cnt3",       stall_cnt, 3);
        out_ready = 1;
        step();
        chk("skid_out_b",      out_data, 32'hB);
        chk("skid_ready_back", in_ready, 1);
        step();
        chk("skid_out_c",      out_data, 32'hC);
        in_valid = 0;
        step();
        chk("skid_empty",      out_valid, 0);
        chk("skid_cnt_final",  stall_cnt, 3);

        // Flush collision while FULL
        out_ready = 0; in_valid = 1; in_data = 32'h1111;
        step();
        in_data = 32'h2222;
        step();
        chk("fl_full", in_ready, 0);
        flush = 1; in_data = 32'h3333; out_ready = 1;
        step();
        flush = 0; in_valid = 0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready",  in_ready,  1);
        chk("fl_main_d",    out_data,  RVAL);
        chk("fl_skid_d",    dut.skid_d, RVAL);
        repeat (3) begin
            step();
            chk("fl_nothing_left", out_valid, 0);
        end

        // Counter saturation and clear
        out_ready = 0; in_valid = 1; in_data = 32'h4444; stall_cnt_clr = 1;
        step();
        in_valid = 0; stall_cnt_clr = 0;
        chk("cnt_start", stall_cnt, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk("cnt_14", stall_cnt, 14);
        end
        chk("cnt_sat", stall_cnt, 15);
        stall_cnt_clr = 1;
        step();
        stall_cnt_clr = 0;
        chk("cnt_clr", stall_cnt, 0);
        step();
        chk("cnt_resume", stall_cnt, 1);

        // Asynchronous reset mid-cycle while FULL
        in_valid = 1; in_data = 32'h5555;
        step();
        in_valid = 0;
        chk("ar_full", in_ready, 0);
        #1;
        Rst = 1;
        model_reset();
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready",  in_ready,  1);
        chk("ar_out_data",  out_data,  RVAL);
        chk("ar_stall_cnt", stall_cnt, 0);
        Rst = 0;
        // First accept right after release
        in_valid = 1; in_data = 32'h6666; out_ready = 1;
        step();
        chk("ar_first_accept", out_data, 32'h6666);

        // Constrained random
        for (int i = 0; i < 10000; i++) begin
            in_valid      = ($urandom % 4) != 0;
            out_ready     = ($urandom % 3) != 0;
            flush         = ($urandom % 50) == 0;
            stall_cnt_clr = ($urandom % 200) == 0;
            in_data       = $urandom;
            step();
        end
        flush = 0; stall_cnt_clr = 0; in_valid = 0; out_ready = 1;
        repeat (3) step();
        chk("rand_drained", out_valid, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
